// File: rtl/riscv_rf_wb_arb.sv
// Round-robin arbiter sharing the register file write port between EX and LS writeback.
// The winner is registered onto the RF port one cycle after its handshake.
module riscv_rf_wb_arb #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_data,
  input  logic                  ls_valid,
  output logic                  ls_ready,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  prio_ls,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (&c) return c;
    return c + CNT_WIDTH'(1);
  endfunction

  logic                  grant_ex_p0;
  logic                  grant_ls_p0;
  logic                  vld_p0;
  logic                  contend_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] data_p0;

  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  prio_p1;
  logic [CNT_WIDTH-1:0]  cnt_p1;

  // Stage p0: combinational grant; nothing is accepted while rst is high
  always_comb begin
    contend_p0  = ex_valid && ls_valid;
    grant_ex_p0 = !rst && ex_valid && (!ls_valid || !prio_p1);
    grant_ls_p0 = !rst && ls_valid && (!ex_valid || prio_p1);
    vld_p0      = grant_ex_p0 || grant_ls_p0;
    addr_p0     = grant_ex_p0 ? ex_addr : ls_addr;
    data_p0     = grant_ex_p0 ? ex_data : ls_data;
  end

  assign ex_ready = grant_ex_p0;
  assign ls_ready = grant_ls_p0;

  // Stage p1: registered RF write port, priority pointer and contention counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      prio_p1 <= 1'b0;
      cnt_p1  <= '0;
    end else begin
      if (vld_p0) begin
        vld_p1  <= (addr_p0 != '0);
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
        prio_p1 <= grant_ex_p0;
      end else begin
        vld_p1 <= 1'b0;
      end
      if (contend_p0) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign wr_en     = vld_p1;
  assign wr_addr   = addr_p1;
  assign wr_data   = data_p1;
  assign prio_ls   = prio_p1;
  assign stall_cnt = cnt_p1;

endmodule

// File: tb/tb_riscv_rf_wb_arb.sv
// Self-checking bench for riscv_rf_wb_arb: directed scenarios plus randomized
// traffic against a cycle-level reference model of the arbitration rules.
module tb_riscv_rf_wb_arb;
  localparam int DW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ex_valid, ls_valid;
  logic [AW-1:0] ex_addr, ls_addr;
  logic [DW-1:0] ex_data, ls_data;

  logic          ex_ready, ls_ready, wr_en, prio_ls;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [31:0]   stall_cnt;

  logic          s_ex_ready, s_ls_ready, s_wr_en, s_prio_ls;
  logic [AW-1:0] s_wr_addr;
  logic [DW-1:0] s_wr_data;
  logic [3:0]    s_stall_cnt;

  riscv_rf_wb_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr), .ls_data(ls_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prio_ls(prio_ls), .stall_cnt(stall_cnt)
  );

  riscv_rf_wb_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(s_ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
    .ls_valid(ls_valid), .ls_ready(s_ls_ready), .ls_addr(ls_addr), .ls_data(ls_data),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .prio_ls(s_prio_ls), .stall_cnt(s_stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic          m_prio;
  logic          m_wr_en;
  logic          m_dc;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;
  longint        m_total;

  logic [DW-1:0] rf [32];
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  // 0 = no grant, 1 = EX, 2 = LS
  function automatic int exp_grant();
    if (rst) return 0;
    if (ex_valid && ls_valid) return m_prio ? 2 : 1;
    if (ex_valid) return 1;
    if (ls_valid) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] exp_cnt32();
    return (m_total > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_total);
  endfunction

  function automatic logic [3:0] exp_cnt4();
    return (m_total > 15) ? 4'd15 : 4'(m_total);
  endfunction

  task automatic tick();
    int            g;
    logic [AW-1:0] a;
    g = exp_grant();
    if (rst) begin
      m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
      m_prio = 1'b0; m_total = 0; m_dc = 1'b0;
    end else begin
      if (g != 0) begin
        a         = (g == 1) ? ex_addr : ls_addr;
        m_wr_en   = (a != 0);
        m_dc      = (a == 0);
        m_wr_addr = a;
        m_wr_data = (g == 1) ? ex_data : ls_data;
        m_prio    = (g == 1);
      end else begin
        m_wr_en = 1'b0;
      end
      if (ex_valid && ls_valid) m_total++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ls_valid = 1'b0;
    ex_addr = '0; ls_addr = '0; ex_data = '0; ls_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_valid = 1'b1; ls_valid = 1'b1;
    ex_addr = 5'd9; ls_addr = 5'd10; ex_data = 64'h11; ls_data = 64'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ex_ready !== 1'b0 || ls_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ready: got ex=%b ls=%b expected 0 0", ex_ready, ls_ready);
      end
      tick();
      n_checks++;
      if (wr_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_wr_en: got %b expected 0", wr_en);
      end
    end
    rst = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if (stall_cnt !== 32'd0 || prio_ls !== 1'b0 || wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d prio=%b wr_en=%b addr=%0d data=%h expected all zero",
               stall_cnt, prio_ls, wr_en, wr_addr, wr_data);
    end
    tick();
  endtask

  task automatic test_ex_alone();
    ex_valid = 1'b1; ex_addr = 5'd5; ex_data = 64'h1234;
    #1;
    n_checks++;
    if (ex_ready !== 1'b1 || ls_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ex_alone_ready: got ex=%b ls=%b expected 1 0", ex_ready, ls_ready);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'h1234) begin
      n_fail++;
      $display("FAIL ex_alone_write: got en=%b addr=%0d data=%h expected 1 5 1234", wr_en, wr_addr, wr_data);
    end
    tick();
    n_checks++;
    if (wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL ex_alone_idle: got wr_en=%b expected 0", wr_en);
    end
  endtask

  task automatic test_contention();
    do_reset();
    ex_valid = 1'b1; ex_addr = 5'd3; ex_data = 64'hA;
    ls_valid = 1'b1; ls_addr = 5'd4; ls_data = 64'hB;
    #1;
    n_checks++;
    if (ex_ready !== 1'b1 || ls_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL contend_c0_grant: got ex=%b ls=%b expected 1 0", ex_ready, ls_ready);
    end
    tick();
    ex_valid = 1'b0;
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 64'hA) begin
      n_fail++;
      $display("FAIL contend_c0_write: got en=%b addr=%0d data=%h expected 1 3 a", wr_en, wr_addr, wr_data);
    end
    n_checks++;
    if (ls_ready !== 1'b1 || ex_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL contend_c1_grant: got ex=%b ls=%b expected 0 1", ex_ready, ls_ready);
    end
    tick();
    ls_valid = 1'b0;
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 64'hB || stall_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL contend_c1_write: got en=%b addr=%0d data=%h cnt=%0d expected 1 4 b 1",
               wr_en, wr_addr, wr_data, stall_cnt);
    end
    tick();
  endtask

  task automatic test_x0_suppression();
    ex_valid = 1'b1; ex_addr = 5'd2; ex_data = 64'h77;
    tick();
    idle_inputs();
    n_checks++;
    if (prio_ls !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_prio_before: got %b expected 1", prio_ls);
    end
    ls_valid = 1'b1; ls_addr = 5'd0; ls_data = 64'hFFFF;
    #1;
    n_checks++;
    if (ls_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_ready: got %b expected 1", ls_ready);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (wr_en !== 1'b0 || prio_ls !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_write: got wr_en=%b prio=%b expected 0 0", wr_en, prio_ls);
    end
    tick();
  endtask

  task automatic test_same_dest();
    ex_valid = 1'b1; ex_addr = 5'd1; ex_data = 64'h5;
    tick();
    ex_valid = 1'b1; ex_addr = 5'd7; ex_data = 64'd1;
    ls_valid = 1'b1; ls_addr = 5'd7; ls_data = 64'd2;
    #1;
    n_checks++;
    if (prio_ls !== 1'b1 || ls_ready !== 1'b1 || ex_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL same_dest_first: got prio=%b ex=%b ls=%b expected 1 0 1", prio_ls, ex_ready, ls_ready);
    end
    tick();
    ls_valid = 1'b0;
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 64'd2 || ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL same_dest_ls_write: got en=%b addr=%0d data=%h ex_ready=%b expected 1 7 2 1",
               wr_en, wr_addr, wr_data, ex_ready);
    end
    tick();
    ex_valid = 1'b0;
    n_checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 64'd1) begin
      n_fail++;
      $display("FAIL same_dest_ex_write: got en=%b addr=%0d data=%h expected 1 7 1", wr_en, wr_addr, wr_data);
    end
    tick();
    n_checks++;
    if (rf[7] !== 64'd1) begin
      n_fail++;
      $display("FAIL same_dest_final: got x7=%h expected 1", rf[7]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_valid = 1'b1; ls_valid = 1'b1;
    ex_addr = 5'd11; ls_addr = 5'd12;
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || ex_ready) ex_data = {$urandom, $urandom};
      if (i == 0 || ls_ready) ls_data = {$urandom, $urandom};
      #1;
      n_checks++;
      if (ex_ready !== ((i % 2) == 0) || ls_ready !== ((i % 2) == 1)) begin
        n_fail++;
        $display("FAIL sat_alternate[%0d]: got ex=%b ls=%b expected %b %b",
                 i, ex_ready, ls_ready, (i % 2) == 0, (i % 2) == 1);
      end
      tick();
      n_checks++;
      if (s_stall_cnt !== ((i + 1 > 15) ? 4'd15 : 4'(i + 1))) begin
        n_fail++;
        $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, s_stall_cnt, (i + 1 > 15) ? 15 : i + 1);
      end
    end
    n_checks++;
    if (s_stall_cnt !== 4'd15 || stall_cnt !== 32'd20) begin
      n_fail++;
      $display("FAIL sat_final: got cnt4=%0d cnt32=%0d expected 15 20", s_stall_cnt, stall_cnt);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic ex_acc, ls_acc;
    int   g;
    ex_acc = 1'b1; ls_acc = 1'b1;
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!ex_valid || ex_acc) begin
        ex_valid = ($urandom_range(0, 3) != 0);
        ex_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
        ex_data  = {$urandom, $urandom};
      end
      if (!ls_valid || ls_acc) begin
        ls_valid = ($urandom_range(0, 2) != 0);
        ls_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
        ls_data  = {$urandom, $urandom};
      end
      #1;
      g = exp_grant();
      n_checks++;
      if (ex_ready !== (g == 1) || ls_ready !== (g == 2) || s_ex_ready !== (g == 1) || s_ls_ready !== (g == 2)) begin
        n_fail++;
        $display("FAIL rand_grant[%0d]: got ex=%b ls=%b expected %b %b", i, ex_ready, ls_ready, g == 1, g == 2);
      end
      ex_acc = ex_ready;
      ls_acc = ls_ready;
      tick();
      n_checks++;
      if (wr_en !== m_wr_en || prio_ls !== m_prio || stall_cnt !== exp_cnt32() ||
          s_stall_cnt !== exp_cnt4() || s_wr_en !== m_wr_en ||
          (!m_dc && (wr_addr !== m_wr_addr || wr_data !== m_wr_data))) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got en=%b prio=%b cnt=%0d cnt4=%0d addr=%0d data=%h expected %b %b %0d %0d %0d %h",
                 i, wr_en, prio_ls, stall_cnt, s_stall_cnt, wr_addr, wr_data,
                 m_wr_en, m_prio, exp_cnt32(), exp_cnt4(), m_wr_addr, m_wr_data);
      end
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_prio = 1'b0; m_wr_en = 1'b0; m_dc = 1'b0;
    m_wr_addr = '0; m_wr_data = '0; m_total = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_ex_alone();
    test_contention();
    test_x0_suppression();
    test_same_dest();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
